// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states, slice width, nibble count helper.
`default_nettype none

package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE = 4;

  function automatic int nibbles(input int width);
    return width / NIBBLE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/four_bit_carry_lookahead_adder.sv
// 4-bit carry-lookahead adder slice: all carries computed directly from generate/propagate terms.
`default_nettype none

module four_bit_carry_lookahead_adder
  import adder_pkg::*;
(
  input  logic [NIBBLE-1:0] in1,
  input  logic [NIBBLE-1:0] in2,
  input  logic              cin,
  output logic [NIBBLE-1:0] sum,
  output logic              cout
);

  logic [NIBBLE-1:0] w_p;
  logic [NIBBLE-1:0] w_g;
  logic [NIBBLE:0]   w_c;

  assign w_p = in1 ^ in2;
  assign w_g = in1 & in2;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum  = w_p ^ w_c[NIBBLE-1:0];
  assign cout = w_c[NIBBLE];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one nibble per clock through a single 4-bit CLA slice,
// with valid/ready handshakes on both operand input and result output.
`default_nettype none

module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int             N        = nibbles(WIDTH);
  localparam int             IW       = $clog2(N);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < 2 * NIBBLE) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              carry_q, carry_d;
  logic              amsb_q, amsb_d;
  logic              bmsb_q, bmsb_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NIBBLE-1:0] slice_sum;
  logic              slice_cout;

  four_bit_carry_lookahead_adder u_slice (
    .in1  (a_q[NIBBLE-1:0]),
    .in2  (b_q[NIBBLE-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so the forced carry-in replaces cin.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1] ^ sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> NIBBLE;
        b_d     = b_q >> NIBBLE;
        res_d   = {slice_sum, res_q[WIDTH-1:NIBBLE]};
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = res_q;
  assign cout      = carry_q;
  assign ovf       = (amsb_q == bmsb_q) && (res_q[WIDTH-1] != amsb_q);

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: three instances (WIDTH 8/16/32) against an arithmetic reference model.
`default_nettype none

module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv   [3] = '{1'b0, 1'b0, 1'b0};
  logic        ordy [3] = '{1'b0, 1'b0, 1'b0};
  logic        ci_v [3] = '{1'b0, 1'b0, 1'b0};
  logic        sb_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] a_v  [3] = '{32'd0, 32'd0, 32'd0};
  logic [31:0] b_v  [3] = '{32'd0, 32'd0, 32'd0};

  logic        ir [3];
  logic        ov [3];
  logic        co [3];
  logic        of [3];
  logic [31:0] sm [3];
  logic [7:0]  sum8;
  logic [15:0] sum16;
  logic [31:0] sum32;

  assign sm[0] = {24'd0, sum8};
  assign sm[1] = {16'd0, sum16};
  assign sm[2] = sum32;

  nibble_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(ci_v[0]), .sub(sb_v[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum8), .cout(co[0]), .ovf(of[0])
  );

  nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]), .cin(ci_v[1]), .sub(sb_v[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum16), .cout(co[1]), .ovf(of[1])
  );

  nibble_serial_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(ci_v[2]), .sub(sb_v[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum32), .cout(co[2]), .ovf(of[2])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int wid(input int k);
    return (k == 0) ? 8 : (k == 1) ? 16 : 32;
  endfunction

  // Reference: plain modular arithmetic for sum/cout, true signed range test for overflow.
  function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input logic ci, input logic sb,
                                output logic [31:0] s, output logic c, output logic o);
    longint m, ua, ub, full, sa, sbv, t;
    m    = longint'(1) << w;
    ua   = longint'(av) & (m - 1);
    ub   = longint'(bv) & (m - 1);
    full = sb ? (ua + (m - ub)) : (ua + ub + longint'(ci));
    s    = 32'(full % m);
    c    = (full >= m);
    sa   = (ua >= m / 2) ? ua - m : ua;
    sbv  = (ub >= m / 2) ? ub - m : ub;
    t    = sb ? (sa - sbv) : (sa + sbv + longint'(ci));
    o    = (t >= m / 2) || (t < -(m / 2));
  endfunction

  task automatic do_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic sb, input bit rnd, input int hold);
    int          w;
    int          cyc;
    bit          done;
    logic [31:0] es;
    logic        ec, eo;
    w = wid(k);
    model(w, av, bv, ci, sb, es, ec, eo);
    @(negedge clk);
    chk("in_ready_idle", 64'(ir[k]), 64'd1);
    iv[k] = 1'b1; a_v[k] = av; b_v[k] = bv; ci_v[k] = ci; sb_v[k] = sb; ordy[k] = 1'b0;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    a_v[k] = $urandom; b_v[k] = $urandom; ci_v[k] = 1'($urandom); sb_v[k] = 1'($urandom);
    cyc = 0;
    while (!ov[k] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(w / 4));
    if (cyc >= 200) return;
    chk("sum", 64'(sm[k]), 64'(es));
    chk("cout", 64'(co[k]), 64'(ec));
    chk("ovf", 64'(of[k]), 64'(eo));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      ordy[k] = 1'b0; iv[k] = 1'b1; a_v[k] = $urandom; b_v[k] = $urandom;
      @(posedge clk); #1;
      chk("hold_out_valid", 64'(ov[k]), 64'd1);
      chk("hold_in_ready", 64'(ir[k]), 64'd0);
      chk("hold_sum", 64'(sm[k]), 64'(es));
      chk("hold_cout", 64'(co[k]), 64'(ec));
      chk("hold_ovf", 64'(of[k]), 64'(eo));
    end
    iv[k] = 1'b0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      ordy[k] = rnd ? 1'($urandom) : 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (ordy[k]) done = 1'b1;
      else chk("stall_sum", 64'(sm[k]), 64'(es));
    end
    ordy[k] = 1'b0;
    chk("out_valid_drop", 64'(ov[k]), 64'd0);
    chk("in_ready_back", 64'(ir[k]), 64'd1);
  endtask

  initial begin
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 64'(ir[k]), 64'd1);
      chk("rst_out_valid", 64'(ov[k]), 64'd0);
      chk("rst_sum", 64'(sm[k]), 64'd0);
      chk("rst_cout_ovf", {62'd0, co[k], of[k]}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1, 32'h1234, 32'h4321, 1'b0, 1'b0, 1'b0, 0);
    do_op(1, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b0, 0);
    do_op(1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b0, 0);
    do_op(1, 32'h0005, 32'h0007, 1'b1, 1'b1, 1'b0, 0);
    do_op(1, 32'h8000, 32'h0001, 1'b0, 1'b1, 1'b0, 0);
    do_op(1, 32'h00FF, 32'h0F01, 1'b1, 1'b0, 1'b0, 3);

    // Reset while RUN sits at idx 2.
    @(negedge clk);
    iv[1] = 1'b1; a_v[1] = 32'h1111; b_v[1] = 32'h2222; ci_v[1] = 1'b0; sb_v[1] = 1'b0;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 64'(ov[1]), 64'd0);
    chk("midrun_rst_sum", 64'(sm[1]), 64'd0);
    chk("midrun_rst_in_ready", 64'(ir[1]), 64'd1);
    iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 64'(ir[1]), 64'd1);
    do_op(1, 32'h0001, 32'h0001, 1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      do_op(0, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1, 0);
      do_op(2, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1, 0);
    end
    do_op(0, 32'h80, 32'h80, 1'b0, 1'b0, 1'b1, 0);
    do_op(2, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 0);
    do_op(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder/subtractor built around one `four_bit_carry_lookahead_adder` slice. It accepts two operands through a valid/ready handshake and feeds the slice one nibble per clock, LSB nibble first, through a registered ripple carry. It then presents the full sum, carry-out and signed overflow through a second valid/ready handshake. It sits directly upstream of the 4-bit CLA, which it drives and whose `sum`/`cout` it consumes, and trades latency for area in wide datapaths.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and at least 8.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands and mode are valid.
- `in_ready` out 1: block can accept operands. High only in IDLE.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `cin` in 1: carry-in. Ignored when `sub`=1.
- `sub` in 1: 1 selects A−B, computed as A+~B+1.
- `out_valid` out 1: result valid. High only in DONE.
- `out_ready` in 1: consumer accepts the result.
- `sum` out WIDTH: result, modulo 2^WIDTH.
- `cout` out 1: carry out of the MSB. In subtract mode, 1 means no borrow.
- `ovf` out 1: two's-complement overflow.

## Operation
- N = WIDTH/4 nibbles. Nibble counter `idx` is $clog2(N) bits wide.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
    - load A into the A shift register;
    - load B, or ~B when `sub`=1, into the B shift register;
    - set the carry register to `sub` ? 1 : `cin`;
    - latch the MSBs of A and of effective B;
    - set `idx`=0 and go to RUN.
  - RUN: the slice sees the low nibbles of the A and B registers plus the carry register. Each cycle:
    - shift the A and B registers right by 4;
    - shift the slice `sum` into the top nibble of the result register, which shifts right by 4;
    - load the slice `cout` into the carry register;
    - increment `idx`.
    - On the cycle with `idx`==N−1, go to DONE.
  - DONE: `out_valid`=1. `sum`, `cout` (the carry register) and `ovf` are stable. On `out_valid`&&`out_ready`, go to IDLE.
- Overflow: `ovf` = (A_msb == Beff_msb) && (sum[WIDTH−1] != A_msb). It is computed from the latched MSBs and is valid in DONE.
- `sub` effectively ignores `cin`: the initial carry is forced to 1.
- `in_valid` or `out_ready` asserted in the wrong state has no effect. Inputs `a`, `b`, `cin` and `sub` are sampled only on the accepting edge.

## Timing
- Reset (`rst_n`=0, at any time, including mid-RUN):
  - state returns to IDLE immediately;
  - all registers clear to 0;
  - `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0;
  - `in_ready`=1 (the IDLE decode). Handshakes are ignored while `rst_n`=0.
- Latency: acceptance on edge T0 puts the first nibble into the slice during cycle T0+1. `out_valid` rises after edge T0+N, which is 4 cycles for WIDTH=16.
- Throughput: one operation per N+2 cycles when `out_ready` is held high. The extra two cycles are the DONE cycle and the IDLE cycle.
- Backpressure: in DONE with `out_ready`=0, every output holds indefinitely and `in_ready` stays 0.
- Outputs are registered; there is no combinational path from inputs to outputs. `in_ready` and `out_valid` decode directly from the state register.

## Structure
- Shared package `adder_pkg`:
  - FSM state enum (IDLE, RUN, DONE, 2 bits);
  - `NIBBLE` = 4;
  - a function returning N from WIDTH.
- One sub-module: an instance of `four_bit_carry_lookahead_adder`. Its ports `in1`, `in2` and `cin` connect to the register low nibbles and the carry register; `sum` and `cout` are consumed.
- Everything else is a single always_ff for state and registers plus combinational output decode. An elaboration-time check enforces the WIDTH rules.

## Test plan
- WIDTH=16, accept `a`=0x1234, `b`=0x4321, `cin`=0, `sub`=0 → `out_valid` 4 cycles after acceptance with `sum`=0x5555, `cout`=0, `ovf`=0.
- 0xFFFF + 0x0001, `cin`=0 → `sum`=0x0000, `cout`=1, `ovf`=0. Then 0x7FFF + 0x0001 → `sum`=0x8000, `cout`=0, `ovf`=1.
- `sub`=1, `a`=0x0005, `b`=0x0007, `cin`=1 (ignored) → `sum`=0xFFFE, `cout`=0, `ovf`=0. Then 0x8000 − 0x0001 → `sum`=0x7FFF, `cout`=1, `ovf`=1.
- Hold `out_ready`=0 for 3 cycles in DONE → `sum`, `cout`, `ovf` and `out_valid` stable, `in_ready`=0, and a new `in_valid` is ignored. After the release, `in_ready`=1 one cycle later.
- Assert `rst_n`=0 while RUN is at `idx`=2 → `out_valid`=0 and `sum`=0 immediately, IDLE after release. A following 0x0001 + 0x0001 yields 0x0002.
- Random sweep with WIDTH=8 and WIDTH=32, `out_ready` toggled randomly → every result matches the reference model of a±b±cin with its `cout` and `ovf`.
